// File: rtl/write_dest_pipe.sv
// Destination-register pipeline from decode to write-back, with hazard
// detection against every in-flight write and a saturating commit counter.
module write_dest_pipe #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 3,
  parameter int LINK_REG = 31
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        RegDst,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              RegWrite,
  input  logic              in_valid,
  input  logic              stall,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs_q,
  input  logic [ADDR_W-1:0] rt_q,
  output logic [ADDR_W-1:0] WriteRegister,
  output logic              wb_we,
  output logic              hazard_rs,
  output logic              hazard_rt,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] dist_rs,
  output logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] dist_rt,
  output logic [15:0]       write_count
);
  localparam int DIST_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0][ADDR_W-1:0] addrPipe;
  logic [DEPTH-1:0]             wePipe;
  logic [DEPTH-1:0]             matchRs, matchRt;
  logic [ADDR_W-1:0]            newAddr;
  logic                         newWe;

  always_comb begin
    newAddr = '0;
    case (RegDst)
      2'b00:   newAddr = rt;
      2'b01:   newAddr = rd;
      2'b10:   newAddr = ADDR_W'(LINK_REG);
      default: newAddr = '0;
    endcase
  end

  // Register 0 is hardwired, so writes to it never enter the pipe as live.
  assign newWe = in_valid && RegWrite && (RegDst != 2'b11) && (newAddr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addrPipe <= '0;
      wePipe   <= '0;
    end else if (flush) begin
      addrPipe <= '0;
      wePipe   <= '0;
    end else if (!stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        addrPipe[k] <= addrPipe[k-1];
        wePipe[k]   <= wePipe[k-1];
      end
      addrPipe[0] <= newAddr;
      wePipe[0]   <= newWe;
    end
  end

  // A stalled last-stage entry is held back and commits on the first free cycle.
  assign wb_we         = wePipe[DEPTH-1] && !stall && !flush;
  assign WriteRegister = wePipe[DEPTH-1] ? addrPipe[DEPTH-1] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      write_count <= '0;
    else if (wb_we && write_count != 16'hFFFF)
      write_count <= write_count + 16'd1;
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_match
    assign matchRs[k] = wePipe[k] && (addrPipe[k] == rs_q);
    assign matchRt[k] = wePipe[k] && (addrPipe[k] == rt_q);
  end

  assign hazard_rs = (rs_q != '0) && (|matchRs);
  assign hazard_rt = (rt_q != '0) && (|matchRt);

  // Scan oldest to youngest so the youngest match wins.
  always_comb begin
    dist_rs = '0;
    dist_rt = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (matchRs[k] && rs_q != '0) dist_rs = DIST_W'(k);
      if (matchRt[k] && rt_q != '0) dist_rt = DIST_W'(k);
    end
  end

endmodule

// File: tb/tb_write_dest_pipe.sv
// Directed bench for write_dest_pipe at DEPTH=3 with hand-computed expectations.
module tb_write_dest_pipe;
  logic       clk = 0;
  logic       rst_n;
  logic [1:0] RegDst;
  logic [4:0] rt, rd, rs_q, rt_q;
  logic       RegWrite, in_valid, stall, flush;
  logic [4:0] WriteRegister;
  logic       wb_we, hazard_rs, hazard_rt;
  logic [1:0] dist_rs, dist_rt;
  logic [15:0] write_count;

  int total = 0;
  int bad   = 0;

  write_dest_pipe #(.ADDR_W(5), .DEPTH(3), .LINK_REG(31)) dut (
    .clk(clk), .rst_n(rst_n), .RegDst(RegDst), .rt(rt), .rd(rd),
    .RegWrite(RegWrite), .in_valid(in_valid), .stall(stall), .flush(flush),
    .rs_q(rs_q), .rt_q(rt_q), .WriteRegister(WriteRegister), .wb_we(wb_we),
    .hazard_rs(hazard_rs), .hazard_rt(hazard_rt), .dist_rs(dist_rs),
    .dist_rt(dist_rt), .write_count(write_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegDst = 2'b01; rt = 0; rd = 0; RegWrite = 0; in_valid = 0;
    stall = 0; flush = 0;
  endtask

  task automatic issue(input logic [1:0] dst, input logic [4:0] t, input logic [4:0] d);
    RegDst = dst; rt = t; rd = d; RegWrite = 1; in_valid = 1;
  endtask

  initial begin
    idle(); rs_q = 0; rt_q = 0;
    rst_n = 0;
    #12;
    chk("rst_wr", WriteRegister, 0);
    chk("rst_we", wb_we, 0);
    chk("rst_cnt", write_count, 0);
    #1 rst_n = 1;
    @(negedge clk);

    // single rd write, latency 3
    issue(2'b01, 4, 6); step();
    idle(); step();
    chk("lat_e2_we", wb_we, 0);
    step();
    chk("lat_wr", WriteRegister, 6);
    chk("lat_we", wb_we, 1);
    chk("lat_cnt_pre", write_count, 0);
    step();
    chk("lat_we_off", wb_we, 0);
    chk("lat_cnt", write_count, 1);

    // destination select sequence
    issue(2'b00, 4, 0);  step();
    issue(2'b10, 0, 0);  step();
    issue(2'b11, 0, 9);  step();
    chk("sel_rt_wr", WriteRegister, 4);
    chk("sel_rt_we", wb_we, 1);
    issue(2'b01, 0, 0);  step();
    chk("sel_link_wr", WriteRegister, 31);
    chk("sel_link_we", wb_we, 1);
    idle(); step();
    chk("sel_rsv_wr", WriteRegister, 0);
    chk("sel_rsv_we", wb_we, 0);
    step();
    chk("sel_r0_wr", WriteRegister, 0);
    chk("sel_r0_we", wb_we, 0);
    chk("sel_cnt", write_count, 3);

    // two in-flight writes to r6 in stages 2 and 1
    issue(2'b01, 0, 6); step();
    step();
    idle(); step();
    rs_q = 6; rt_q = 0; #1;
    chk("hz_rs", hazard_rs, 1);
    chk("hz_dist_rs", dist_rs, 1);
    chk("hz_rt0", hazard_rt, 0);
    chk("hz_dist_rt0", dist_rt, 0);
    rt_q = 6; #1;
    chk("hz_rt", hazard_rt, 1);
    chk("hz_dist_rt", dist_rt, 1);
    step();
    chk("hz_dist_old", dist_rs, 2);
    chk("hz_cnt4", write_count, 4);
    step();
    chk("hz_clear", hazard_rs, 0);
    chk("hz_cnt5", write_count, 5);
    rs_q = 0; rt_q = 0;

    // stall delays a write by two cycles, commits once
    issue(2'b01, 0, 7); step();
    idle(); stall = 1; rs_q = 7; #1;
    chk("st_hz", hazard_rs, 1);
    chk("st_dist", dist_rs, 0);
    step(); step();
    stall = 0; step();
    chk("st_e4_we", wb_we, 0);
    step();
    chk("st_wr", WriteRegister, 7);
    chk("st_we", wb_we, 1);
    step();
    chk("st_we_once", wb_we, 0);
    chk("st_cnt", write_count, 6);

    // flush with stall kills everything, including the new entry
    issue(2'b01, 0, 9); step();
    issue(2'b01, 0, 8); stall = 1; flush = 1; step();
    idle(); rs_q = 9; rt_q = 8; #1;
    chk("fl_hz_rs", hazard_rs, 0);
    chk("fl_hz_rt", hazard_rt, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("fl_no_commit", wb_we, 0);
    end
    chk("fl_cnt", write_count, 6);

    // async reset with three entries in flight
    issue(2'b01, 0, 10); step();
    issue(2'b01, 0, 11); step();
    issue(2'b01, 0, 12); step();
    idle(); rs_q = 10; rt_q = 12;
    #2 rst_n = 0;
    #1;
    chk("ar_wr", WriteRegister, 0);
    chk("ar_we", wb_we, 0);
    chk("ar_hz_rs", hazard_rs, 0);
    chk("ar_hz_rt", hazard_rt, 0);
    chk("ar_cnt", write_count, 0);
    @(negedge clk); rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ar_no_commit", wb_we, 0);
    end
    issue(2'b01, 0, 13); step();
    idle(); step(); step();
    chk("ar_new_wr", WriteRegister, 13);
    chk("ar_new_we", wb_we, 1);

    // saturation: continuous writes from reset
    rst_n = 0; #1; rst_n = 1;
    issue(2'b01, 0, 1);
    for (int i = 0; i < 65537; i++) @(posedge clk);
    #1;
    chk("sat_fffe", write_count, 16'hFFFE);
    step();
    chk("sat_ffff", write_count, 16'hFFFF);
    step(); step();
    chk("sat_hold", write_count, 16'hFFFF);
    chk("sat_we", wb_we, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
